if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/if_id_reg.sv | 32 +++
 rtl/if_id_stage.sv | 126 ++++++++++++
 tb/tb_if_id_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction fetch front end: fetch FSM encoding,
// default reset PC / bubble instruction, and PC increment helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_BUF  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // Wraps modulo 2^32 by construction of the 32-bit result.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (bubble) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= next_instr;
            pc_plus4 <= next_pc4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage: fetch-address FSM with one-entry skid buffer and
// stale-fetch dropping, feeding the IF/ID register.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_if_write_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_id_o,
    output logic [31:0] pc_plus4_id_o,
    output logic        valid_id_o
);

    fetch_state_t state;
    logic [31:0]  fetch_addr;
    logic [31:0]  pend_pc;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc4;
    logic [31:0]  fetch_pc4;
    logic         req_q;

    logic         id_load;
    logic         id_bubble;
    logic [31:0]  id_next_instr;
    logic [31:0]  id_next_pc4;

    assign fetch_pc4   = pc_plus4(fetch_addr);
    assign imem_addr_o = fetch_addr;
    assign imem_req_o  = req_q;

    // A flush is only honoured when ID is allowed to advance; any accepted
    // flush or a cycle without a usable word turns into a bubble.
    always_comb begin
        id_load       = 1'b0;
        id_bubble     = 1'b0;
        id_next_instr = imem_rdata_i;
        id_next_pc4   = fetch_pc4;
        if (state == ST_BUF) begin
            id_next_instr = buf_instr;
            id_next_pc4   = buf_pc4;
        end
        if (pc_if_write_i) begin
            if (flush_i || state == ST_DROP || (state == ST_REQ && !imem_ready_i))
                id_bubble = 1'b1;
            else
                id_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            req_q      <= 1'b1;
            fetch_addr <= RESET_PC;
            pend_pc    <= 32'd0;
            buf_instr  <= 32'd0;
            buf_pc4    <= 32'd0;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (pc_if_write_i) begin
                        if (flush_i) begin
                            if (imem_ready_i) begin
                                fetch_addr <= redirect_pc_i;
                            end else begin
                                pend_pc <= redirect_pc_i;
                                state   <= ST_DROP;
                            end
                        end else if (imem_ready_i) begin
                            fetch_addr <= fetch_pc4;
                        end
                    end else if (imem_ready_i) begin
                        buf_instr <= imem_rdata_i;
                        buf_pc4   <= fetch_pc4;
                        state     <= ST_BUF;
                        req_q     <= 1'b0;
                    end
                end
                ST_BUF: begin
                    if (pc_if_write_i) begin
                        fetch_addr <= flush_i ? redirect_pc_i : buf_pc4;
                        state      <= ST_REQ;
                        req_q      <= 1'b1;
                    end
                end
                ST_DROP: begin
                    // The in-flight response belongs to the old path; wait it out.
                    if (pc_if_write_i && imem_ready_i) begin
                        fetch_addr <= flush_i ? redirect_pc_i : pend_pc;
                        state      <= ST_REQ;
                    end else if (pc_if_write_i && flush_i) begin
                        pend_pc <= redirect_pc_i;
                    end
                end
                default: begin
                    state <= ST_REQ;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (id_load),
        .bubble     (id_bubble),
        .next_instr (id_next_instr),
        .next_pc4   (id_next_pc4),
        .instr      (instr_id_o),
        .pc_plus4   (pc_plus4_id_o),
        .valid      (valid_id_o)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed scoreboard bench for if_id_stage: each driven cycle pushes its
// expected post-edge outputs, which are popped and compared after the edge.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_if_write_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_id_o;
    logic [31:0] pc_plus4_id_o;
    logic        valid_id_o;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          pc4_care;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: returns a word derived from the requested address.
    assign imem_rdata_i = word_at(imem_addr_o);

    if_id_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_if_write_i (pc_if_write_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_id_o    (instr_id_o),
        .pc_plus4_id_o (pc_plus4_id_o),
        .valid_id_o    (valid_id_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input string tag, input logic rst, input logic rdy, input logic wr,
                       input logic fl, input logic [31:0] redir,
                       input logic [31:0] e_addr, input logic e_req, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4, input bit care);
        exp_t e;
        exp_t got;
        rst_n         = ~rst;
        imem_ready_i  = rdy;
        pc_if_write_i = wr;
        flush_i       = fl;
        redirect_pc_i = redir;
        e.tag = tag; e.addr = e_addr; e.req = e_req; e.valid = e_valid;
        e.instr = e_instr; e.pc4 = e_pc4; e.pc4_care = care;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".addr"},  imem_addr_o,        got.addr);
        check({got.tag, ".req"},   {31'd0, imem_req_o}, {31'd0, got.req});
        check({got.tag, ".valid"}, {31'd0, valid_id_o}, {31'd0, got.valid});
        check({got.tag, ".instr"}, instr_id_o,         got.instr);
        if (got.pc4_care) check({got.tag, ".pc4"}, pc_plus4_id_o, got.pc4);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready_i = 1'b0; pc_if_write_i = 1'b0;
        flush_i = 1'b0; redirect_pc_i = 32'd0;
        //   tag        rst rdy wr fl redirect        addr          req valid instr                    pc4           care
        cyc("reset",     1, 0, 0, 0, 32'h0,         32'h0,          1, 0, NOP,                     32'h0,          1);
        cyc("seq0",      0, 1, 1, 0, 32'h0,         32'h4,          1, 1, word_at(32'h0),          32'h4,          1);
        cyc("seq4",      0, 1, 1, 0, 32'h0,         32'h8,          1, 1, word_at(32'h4),          32'h8,          1);
        cyc("stall1",    0, 1, 0, 0, 32'h0,         32'h8,          0, 1, word_at(32'h4),          32'h8,          1);
        cyc("stall2",    0, 1, 0, 0, 32'h0,         32'h8,          0, 1, word_at(32'h4),          32'h8,          1);
        cyc("unbuf",     0, 1, 1, 0, 32'h0,         32'hC,          1, 1, word_at(32'h8),          32'hC,          1);
        cyc("seqC",      0, 1, 1, 0, 32'h0,         32'h10,         1, 1, word_at(32'hC),          32'h10,         1);
        cyc("flush_ign", 0, 0, 0, 1, 32'h80,        32'h10,         1, 1, word_at(32'hC),          32'h10,         1);
        cyc("flush_nr",  0, 0, 1, 1, 32'h40,        32'h10,         1, 0, NOP,                     32'h0,          0);
        cyc("drop_wait", 0, 0, 1, 0, 32'h0,         32'h10,         1, 0, NOP,                     32'h0,          0);
        cyc("drop_rdy",  0, 1, 1, 0, 32'h0,         32'h40,         1, 0, NOP,                     32'h0,          0);
        cyc("seq40",     0, 1, 1, 0, 32'h0,         32'h44,         1, 1, word_at(32'h40),         32'h44,         1);
        cyc("wait44",    0, 0, 1, 0, 32'h0,         32'h44,         1, 0, NOP,                     32'h0,          0);
        cyc("seq44",     0, 1, 1, 0, 32'h0,         32'h48,         1, 1, word_at(32'h44),         32'h48,         1);
        cyc("buf48",     0, 1, 0, 0, 32'h0,         32'h48,         0, 1, word_at(32'h44),         32'h48,         1);
        cyc("buf_flush", 0, 1, 1, 1, 32'h100,       32'h100,        1, 0, NOP,                     32'h0,          0);
        cyc("seq100",    0, 1, 1, 0, 32'h0,         32'h104,        1, 1, word_at(32'h100),        32'h104,        1);
        cyc("drop_a",    0, 0, 1, 1, 32'h200,       32'h104,        1, 0, NOP,                     32'h0,          0);
        cyc("drop_b",    0, 0, 1, 1, 32'h300,       32'h104,        1, 0, NOP,                     32'h0,          0);
        cyc("drop_done", 0, 1, 1, 0, 32'h0,         32'h300,        1, 0, NOP,                     32'h0,          0);
        cyc("seq300",    0, 1, 1, 0, 32'h0,         32'h304,        1, 1, word_at(32'h300),        32'h304,        1);
        cyc("flush_rdy", 0, 1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC,  1, 0, NOP,                     32'h0,          0);
        cyc("wrap",      0, 1, 1, 0, 32'h0,         32'h0,          1, 1, word_at(32'hFFFF_FFFC),  32'h0,          1);
        cyc("seq0b",     0, 1, 1, 0, 32'h0,         32'h4,          1, 1, word_at(32'h0),          32'h4,          1);
        cyc("drop_c",    0, 0, 1, 1, 32'h500,       32'h4,          1, 0, NOP,                     32'h0,          0);
        cyc("rst_drop",  1, 0, 1, 0, 32'h0,         32'h0,          1, 0, NOP,                     32'h0,          1);
        cyc("post_rst",  0, 1, 1, 0, 32'h0,         32'h4,          1, 1, word_at(32'h0),          32'h4,          1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
